// File: rtl/riscm_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller.
// Holds the FSM state enum, opcode/op field values, ALUop and shift codes,
// and the decoded instruction class used between decoder and sequencer.
package riscm_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALUop codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_MVN = 3'b011;

    // shifter codes
    localparam logic [2:0] SH_NONE = 3'b000;
    localparam logic [2:0] SH_LSL1 = 3'b001;
    localparam logic [2:0] SH_LSR1 = 3'b010;
    localparam logic [2:0] SH_ASR1 = 3'b011;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } instr_class_t;

endpackage

// File: rtl/riscm_instr_decoder.sv
// Purpose: split the latched instruction word into fields and classify it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows ir_i continuously.
// Ports: ir_i (16-bit IR) -> rn_o, rd_o, rm_o, sh_o, imm8_o, cls_o.
module riscm_instr_decoder
    import riscm_pkg::*;
(
    input  logic [15:0]   ir_i,
    output logic [2:0]    rn_o,
    output logic [2:0]    rd_o,
    output logic [2:0]    rm_o,
    output logic [1:0]    sh_o,
    output logic [7:0]    imm8_o,
    output instr_class_t  cls_o
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir_i[15:13];
    assign op     = ir_i[12:11];
    assign rn_o   = ir_i[10:8];
    assign rd_o   = ir_i[7:5];
    assign sh_o   = ir_i[4:3];
    assign rm_o   = ir_i[2:0];
    // imm8 overlaps Rd/sh/Rm; only MOV-immediate interprets it
    assign imm8_o = ir_i[7:0];

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)
                cls_o = CLS_MOV_IMM;
            else if (op == OP_MOV_REG)
                cls_o = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls_o = CLS_ADD;
                OP_CMP:  cls_o = CLS_CMP;
                OP_AND:  cls_o = CLS_AND;
                OP_MVN:  cls_o = CLS_MVN;
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/riscm_controller.sv
// Purpose: sequencing FSM driving the Simple RISC Machine datapath controls.
// Latency: 2..5 busy cycles per instruction (1 for illegal), done/err pulse on next WAIT cycle.
// Backpressure: start accepted only while w=1 (WAIT); ignored otherwise, IR holds.
// Ports: clk, reset_n, start, instr in; w, done, err, readnum, writenum, write,
//        loada/b/c/s, asel, bsel, vsel, ALUop, shift, datapath_in out.
module riscm_controller
    import riscm_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           instr,
    output logic                  w,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            readnum,
    output logic [2:0]            writenum,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic                  vsel,
    output logic [2:0]            ALUop,
    output logic [2:0]            shift,
    output logic [data_width-1:0] datapath_in
);

    state_t       state_q, state_d;
    logic [15:0]  ir_q;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [2:0]   rn, rd, rm;
    logic [1:0]   sh;
    logic [7:0]   imm8;
    instr_class_t cls;

    riscm_instr_decoder u_dec (
        .ir_i   (ir_q),
        .rn_o   (rn),
        .rd_o   (rd),
        .rm_o   (rm),
        .sh_o   (sh),
        .imm8_o (imm8),
        .cls_o  (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (state_q == S_WAIT && start)
                ir_q <= instr;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        ALUop    = ALU_ADD;
        shift    = SH_NONE;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (start)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          state_d = S_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN: state_d = S_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND: state_d = S_GET_A;
                    default: begin
                        state_d = S_WAIT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_WRITE_IMM: begin
                vsel     = 1'b1;
                writenum = rn;
                write    = 1'b1;
                state_d  = S_WAIT;
                done_d   = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                case (sh)
                    2'b00:   shift = SH_NONE;
                    2'b01:   shift = SH_LSL1;
                    2'b10:   shift = SH_LSR1;
                    default: shift = SH_ASR1;
                endcase
                case (cls)
                    CLS_CMP: ALUop = ALU_SUB;
                    CLS_AND: ALUop = ALU_AND;
                    CLS_MVN: ALUop = ALU_MVN;
                    default: ALUop = ALU_ADD;
                endcase
                // single-operand forms pass B through by zeroing A
                asel = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                if (cls == CLS_CMP) begin
                    // CMP only updates flags; there is no write-back
                    loads   = 1'b1;
                    state_d = S_WAIT;
                    done_d  = 1'b1;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = S_WAIT;
                done_d   = 1'b1;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign done        = done_q;
    assign err         = err_q;
    assign bsel        = 1'b0;
    assign datapath_in = {{(data_width-8){imm8[7]}}, imm8};

endmodule

// File: tb/tb_riscm_controller.sv
// Bench for riscm_controller: a queue-based per-instruction cycle model plus
// directed vectors with literal expectations.
module tb_riscm_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] instr;
    logic        w, done, err, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum, ALUop, shift;
    logic [15:0] datapath_in;

    riscm_controller #(.data_width(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .w(w), .done(done), .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
        .datapath_in(datapath_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w, done, err;
        logic [2:0] readnum, writenum;
        logic       write, loada, loadb, loadc, loads, asel, bsel, vsel;
        logic [2:0] aluop, shift;
    } ctl_t;

    int   errors = 0;
    int   checks = 0;
    bit   run_cmp = 1'b0;

    ctl_t        cur;
    ctl_t        q[$];
    logic [15:0] m_ir;

    function automatic ctl_t idle_v();
        ctl_t v = '0;
        v.w = 1'b1;
        return v;
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t v;
        v.w = w; v.done = done; v.err = err;
        v.readnum = readnum; v.writenum = writenum;
        v.write = write; v.loada = loada; v.loadb = loadb; v.loadc = loadc;
        v.loads = loads; v.asel = asel; v.bsel = bsel; v.vsel = vsel;
        v.aluop = ALUop; v.shift = shift;
        return v;
    endfunction

    // Expand one instruction into the list of per-cycle outputs it must
    // produce: busy cycles followed by the WAIT cycle carrying done/err.
    task automatic push_seq(input logic [15:0] ins);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        bit mov_imm, mov_reg, alu, legal, is_cmp, is_mvn;
        ctl_t v;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        legal   = mov_imm || mov_reg || alu;
        is_cmp  = alu && (op == 2'b01);
        is_mvn  = alu && (op == 2'b11);
        q.push_back('0);                         // DECODE
        if (!legal) begin
            v = idle_v(); v.err = 1'b1; q.push_back(v);
            return;
        end
        if (mov_imm) begin
            v = '0; v.writenum = rn; v.vsel = 1'b1; v.write = 1'b1; q.push_back(v);
        end else begin
            if (alu && !is_mvn) begin
                v = '0; v.readnum = rn; v.loada = 1'b1; q.push_back(v);
            end
            v = '0; v.readnum = rm; v.loadb = 1'b1; q.push_back(v);
            v = '0;
            v.shift = {1'b0, sh};
            v.aluop = is_cmp ? 3'd1 : (alu && op == 2'b10) ? 3'd2 : is_mvn ? 3'd3 : 3'd0;
            v.asel  = mov_reg || is_mvn;
            if (is_cmp) begin
                v.loads = 1'b1; q.push_back(v);
            end else begin
                v.loadc = 1'b1; q.push_back(v);
                v = '0; v.writenum = rd; v.write = 1'b1; q.push_back(v);
            end
        end
        v = idle_v(); v.done = 1'b1; q.push_back(v);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            cur  = idle_v();
            m_ir = 16'h0000;
        end else begin
            if (cur.w && start) begin
                m_ir = instr;
                push_seq(instr);
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = idle_v();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            checks++;
            if (dut_ctl() !== cur) begin
                errors++;
                $display("FAIL cycle_ctl: got %h expected %h at %0t", dut_ctl(), cur, $time);
            end
            chk("cycle_datapath_in", {16'h0, datapath_in}, {16'h0, 16'($signed(m_ir[7:0]))});
        end
    end

    task automatic issue(input logic [15:0] ins);
        @(posedge clk); #1;
        start = 1'b1; instr = ins;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count busy negedges until w returns; collect enables and ALUop seen.
    task automatic wait_w(output int busy, output logic [4:0] en_seen, output logic [2:0] alu_seen);
        bit ok = 1'b0;
        busy = 0; en_seen = '0; alu_seen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (w) begin ok = 1'b1; break; end
            busy++;
            en_seen |= {write, loada, loadb, loadc, loads};
            if (loadc || loads) alu_seen = ALUop;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL timeout_w: got w=0 expected w=1 within 30 cycles");
        end
    endtask

    int         busy;
    logic [4:0] en;
    logic [2:0] alu;

    initial begin
        reset_n = 1'b0; start = 1'b0; instr = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w", w, 1);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_enables", {write, loada, loadb, loadc, loads, asel, bsel, vsel}, 0);
        chk("rst_ir", datapath_in, 16'h0000);
        @(negedge clk); reset_n = 1'b1; run_cmp = 1'b1;

        // MOV R3,#-5
        issue(16'hD3FB);
        @(negedge clk); chk("mov_decode_w", w, 0);
        @(negedge clk);
        chk("mov_writenum", writenum, 3);
        chk("mov_vsel_write", {vsel, write}, 2'b11);
        chk("mov_dp_in", datapath_in, 16'hFFFB);
        @(negedge clk); chk("mov_done_w", {done, w, err}, 3'b110);

        // ADD R2,R1,R0,LSL#1
        issue(16'hA148);
        @(negedge clk); chk("add_decode", {w, loada, loadb}, 0);
        @(negedge clk); chk("add_geta", {readnum, loada}, {3'd1, 1'b1});
        @(negedge clk); chk("add_getb", {readnum, loadb}, {3'd0, 1'b1});
        @(negedge clk); chk("add_alu", {ALUop, shift, loadc, asel}, {3'b000, 3'b001, 1'b1, 1'b0});
        @(negedge clk); chk("add_wr", {writenum, write, vsel}, {3'd2, 1'b1, 1'b0});
        @(negedge clk); chk("add_done", {done, w}, 2'b11);

        // CMP R1,R4
        issue(16'hA904);
        wait_w(busy, en, alu);
        chk("cmp_busy", busy, 4);
        chk("cmp_enables", en, 5'b01101);
        chk("cmp_aluop", alu, 3'b001);
        chk("cmp_done", {done, err}, 2'b10);

        // Illegal opcode
        issue(16'hE000);
        wait_w(busy, en, alu);
        chk("ill_busy", busy, 1);
        chk("ill_enables", en, 0);
        chk("ill_err", {err, done}, 2'b10);

        // MVN R5,R6 with start held/toggled, then ADD accepted on done cycle
        @(posedge clk); #1;
        start = 1'b1; instr = 16'hB8A6;
        @(posedge clk); #1;
        instr = 16'hA148;
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (w) break;
            busy++;
            start = ~start;
        end
        start = 1'b1;
        chk("mvn_busy", busy, 4);
        chk("mvn_done", {done, w}, 2'b11);
        @(posedge clk); #1; start = 1'b0;
        wait_w(busy, en, alu);
        chk("b2b_busy", busy, 5);
        chk("b2b_done", done, 1);

        // Reset asserted in GET_B of an ADD
        issue(16'hA148);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("rst_mid_getb", loadb, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_w", w, 1);
        chk("rst_mid_en", {write, loadb, loadc}, 0);
        chk("rst_mid_ir", datapath_in, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        en = '0;
        repeat (4) begin
            @(negedge clk);
            en |= {write, loada, loadb, loadc, loads};
        end
        chk("rst_mid_quiet", {en, done, w}, {5'b0, 1'b0, 1'b1});

        // Recovery: MOV R0,#0x7F
        issue(16'hD07F);
        wait_w(busy, en, alu);
        chk("rec_busy", busy, 2);
        chk("rec_dp_in", datapath_in, 16'h007F);

        repeat (3) @(negedge clk);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
